// File: rtl/tlc_timed.sv
// tlc_timed: timed traffic-light controller for a main/side intersection.
// Main green holds until side or left-turn demand arrives. Side green extends
// while the side sensor stays high, up to a maximum dwell. Every phase change
// passes through yellow and all-red.
// Optional feature: define TLC_ARROW_EN to enable the main left-turn arrow
// phase and the MD sensor. When it is undefined, MA stays 0, MD is ignored
// and encoding 7 decodes as an illegal state.
module tlc_timed #(
  parameter int TW           = 8,
  parameter int T_ALLRED     = 1,
  parameter int T_YELLOW     = 2,
  parameter int T_MGREEN_MIN = 3,
  parameter int T_SGREEN     = 2,
  parameter int T_SGREEN_MAX = 5,
  parameter int T_ARROW      = 2
) (
  input  logic       CLK,
  input  logic       clr,
  input  logic       MD,
  input  logic       SD,
  output logic       MR,
  output logic       MY,
  output logic       MG,
  output logic       MA,
  output logic       SR,
  output logic       SY,
  output logic       SG,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    M_GREEN  = 3'd1,
    M_YELLOW = 3'd2,
    ALLRED1  = 3'd3,
    S_GREEN  = 3'd4,
    S_YELLOW = 3'd5,
    ALLRED2  = 3'd6,
    ARROW    = 3'd7
  } state_t;

  // A dwell of T cycles has elapsed once the timer reaches T-1.
  localparam logic [TW-1:0] ALLRED_LAST  = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] YELLOW_LAST  = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] MGREEN_LAST  = TW'(T_MGREEN_MIN - 1);
  localparam logic [TW-1:0] SGREEN_LAST  = TW'(T_SGREEN - 1);
  localparam logic [TW-1:0] SGMAX_LAST   = TW'(T_SGREEN_MAX - 1);
  localparam logic [TW-1:0] TIMER_MAX    = '1;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic          sd_req;
  logic          md_req;
  logic          enter_sgreen;
  logic          enter_arrow;

  assign enter_sgreen = (state_nxt == S_GREEN) && (state != S_GREEN);
  assign enter_arrow  = (state_nxt == ARROW)   && (state != ARROW);

`ifdef TLC_ARROW_EN
  localparam logic [TW-1:0] ARROW_LAST = TW'(T_ARROW - 1);
`else
  // MD has no function in this build; it is kept only to hold the port list fixed.
  logic unused_md;
  assign unused_md = MD;
`endif

  // State, dwell timer and demand latches.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation ordering cannot leak in.
  always_ff @(posedge CLK or posedge clr) begin
    if (clr) begin
      state  <= INIT;
      timer  <= '0;
      sd_req <= 1'b0;
      md_req <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        timer <= '0;
      end else if (timer != TIMER_MAX) begin
        timer <= timer + 1'b1;
      end
      // A sensor high in the clearing cycle re-arms the latch.
      sd_req <= (sd_req & ~enter_sgreen) | SD;
`ifdef TLC_ARROW_EN
      md_req <= (md_req & ~enter_arrow) | MD;
`else
      md_req <= 1'b0;
`endif
    end
  end

  // Next-state selection from timer and latched demand. Side-green extension
  // looks at the live SD sensor.
  // NOTE: state_nxt is given a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT: begin
        if (timer >= ALLRED_LAST) state_nxt = M_GREEN;
      end
      M_GREEN: begin
        if ((timer >= MGREEN_LAST) && (sd_req || md_req)) state_nxt = M_YELLOW;
      end
      M_YELLOW: begin
        if (timer >= YELLOW_LAST) state_nxt = ALLRED1;
      end
      ALLRED1: begin
        if (timer >= ALLRED_LAST) begin
          state_nxt = (md_req && !sd_req) ? ARROW : S_GREEN;
        end
      end
      S_GREEN: begin
        if ((timer >= SGMAX_LAST) || ((timer >= SGREEN_LAST) && !SD)) begin
          state_nxt = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (timer >= YELLOW_LAST) state_nxt = ALLRED2;
      end
      ALLRED2: begin
        if (timer >= ALLRED_LAST) state_nxt = md_req ? ARROW : M_GREEN;
      end
`ifdef TLC_ARROW_EN
      ARROW: begin
        if (timer >= ARROW_LAST) state_nxt = INIT;
      end
`endif
      default: state_nxt = INIT;
    endcase
  end

  // Moore lamp decode from the state register only. Unknown encodings show all-red.
  always_comb begin
    MR = 1'b0;
    MY = 1'b0;
    MG = 1'b0;
    MA = 1'b0;
    SR = 1'b0;
    SY = 1'b0;
    SG = 1'b0;
    case (state)
      M_GREEN:  begin MG = 1'b1; SR = 1'b1; end
      M_YELLOW: begin MY = 1'b1; SR = 1'b1; end
      S_GREEN:  begin MR = 1'b1; SG = 1'b1; end
      S_YELLOW: begin MR = 1'b1; SY = 1'b1; end
`ifdef TLC_ARROW_EN
      ARROW:    begin MR = 1'b1; MA = 1'b1; SR = 1'b1; end
`endif
      default:  begin MR = 1'b1; SR = 1'b1; end
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_tlc_timed.sv
// tb_tlc_timed: randomized and directed stimulus for tlc_timed. Expected
// outputs come from a cycle-level phase/dwell reference model and go into a
// queue. A negedge monitor pops them and compares them with the lamps and phase.
module tb_tlc_timed;

  localparam int TW           = 8;
  localparam int T_ALLRED     = 1;
  localparam int T_YELLOW     = 2;
  localparam int T_MGREEN_MIN = 3;
  localparam int T_SGREEN     = 2;
  localparam int T_SGREEN_MAX = 5;
  localparam int T_ARROW      = 2;
  localparam int TMAX         = (1 << TW) - 1;

`ifdef TLC_ARROW_EN
  localparam bit ARROW_EN = 1'b1;
`else
  localparam bit ARROW_EN = 1'b0;
`endif

  localparam int P_INIT = 0, P_MGREEN = 1, P_MYELLOW = 2, P_ALLRED1 = 3;
  localparam int P_SGREEN = 4, P_SYELLOW = 5, P_ALLRED2 = 6, P_ARROW = 7;

  logic       CLK = 1'b0;
  logic       clr;
  logic       MD, SD;
  logic       MR, MY, MG, MA, SR, SY, SG;
  logic [2:0] phase;

  tlc_timed #(
    .TW(TW), .T_ALLRED(T_ALLRED), .T_YELLOW(T_YELLOW),
    .T_MGREEN_MIN(T_MGREEN_MIN), .T_SGREEN(T_SGREEN),
    .T_SGREEN_MAX(T_SGREEN_MAX), .T_ARROW(T_ARROW)
  ) dut (
    .CLK(CLK), .clr(clr), .MD(MD), .SD(SD),
    .MR(MR), .MY(MY), .MG(MG), .MA(MA),
    .SR(SR), .SY(SY), .SG(SG), .phase(phase)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: current phase, cycles already spent in it, and the
  // two demand latches.
  int m_phase;
  int m_el;
  bit m_sd;
  bit m_md;

  logic [9:0] exp_q[$];

  task automatic model_reset();
    m_phase = P_INIT;
    m_el    = 0;
    m_sd    = 1'b0;
    m_md    = 1'b0;
  endtask

  // Lamp set for a phase, packed as {MR,MY,MG,MA,SR,SY,SG}.
  function automatic logic [6:0] lamps_of(input int p);
    case (p)
      P_MGREEN:  return 7'b0010100;
      P_MYELLOW: return 7'b0100100;
      P_SGREEN:  return 7'b1000001;
      P_SYELLOW: return 7'b1000010;
      P_ARROW:   return ARROW_EN ? 7'b1001100 : 7'b1000100;
      default:   return 7'b1000100;
    endcase
  endfunction

  function automatic logic [9:0] expect_of(input int p);
    logic [2:0] pe;
    pe = 3'(p);
    return {pe, lamps_of(p)};
  endfunction

  // Advance the model across one clock edge with the sensor values seen at that edge.
  task automatic model_step(input bit sd, input bit md);
    int held;
    int nxt;
    held = m_el + 1;
    nxt  = m_phase;
    case (m_phase)
      P_INIT:    if (held >= T_ALLRED) nxt = P_MGREEN;
      P_MGREEN:  if (held >= T_MGREEN_MIN && (m_sd || m_md)) nxt = P_MYELLOW;
      P_MYELLOW: if (held >= T_YELLOW) nxt = P_ALLRED1;
      P_ALLRED1: if (held >= T_ALLRED) nxt = (m_md && !m_sd) ? P_ARROW : P_SGREEN;
      P_SGREEN:  if (held >= T_SGREEN_MAX || (held >= T_SGREEN && !sd)) nxt = P_SYELLOW;
      P_SYELLOW: if (held >= T_YELLOW) nxt = P_ALLRED2;
      P_ALLRED2: if (held >= T_ALLRED) nxt = m_md ? P_ARROW : P_MGREEN;
      P_ARROW:   if (held >= T_ARROW) nxt = P_INIT;
      default:   nxt = P_INIT;
    endcase
    m_sd = (m_sd && !(nxt == P_SGREEN && m_phase != P_SGREEN)) || sd;
    m_md = ARROW_EN && ((m_md && !(nxt == P_ARROW && m_phase != P_ARROW)) || md);
    if (nxt != m_phase) m_el = 0;
    else if (m_el < TMAX) m_el = m_el + 1;
    m_phase = nxt;
  endtask

  // One clock: step the model at the edge, queue the expectation, then present new sensors.
  task automatic drive(input bit sd, input bit md);
    @(posedge CLK);
    model_step(SD, MD);
    exp_q.push_back(expect_of(m_phase));
    #1;
    SD = sd;
    MD = md;
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per falling edge.
  always @(negedge CLK) begin
    logic [9:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("lamps_phase", {22'd0, phase, MR, MY, MG, MA, SR, SY, SG}, {22'd0, e});
    end
  end

  initial begin
    int n;
    clr = 1'b1;
    SD  = 1'b0;
    MD  = 1'b0;
    model_reset();
    #2;
    check("reset_out", {22'd0, phase, MR, MY, MG, MA, SR, SY, SG}, {22'd0, expect_of(P_INIT)});
    @(negedge CLK);
    @(negedge CLK);
    #1 clr = 1'b0;
    check("reset_sd_req", {31'd0, dut.sd_req}, 32'd0);

    // No demand: one INIT cycle, then main green indefinitely.
    repeat (25) drive(1'b0, 1'b0);

    // Single side pulse with the main-green minimum already met.
    drive(1'b1, 1'b0);
    repeat (15) drive(1'b0, 1'b0);

    // Side sensor held high: side green is capped at its maximum dwell.
    repeat (20) drive(1'b1, 1'b0);
    repeat (12) drive(1'b0, 1'b0);

    // Left-turn pulse alone.
    drive(1'b0, 1'b1);
    repeat (15) drive(1'b0, 1'b0);

    // Left-turn and side pulses together: side first, then the arrow.
    drive(1'b1, 1'b1);
    repeat (20) drive(1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0);
    end
    repeat (10) drive(1'b0, 1'b0);

    // Asynchronous reset between edges while side green is lit.
    n = 0;
    while (m_phase != P_SGREEN && n < 60) begin
      drive(1'b1, 1'b1);
      n++;
    end
    check("reach_sgreen", {29'd0, phase}, 32'd4);
    @(negedge CLK);
    #1 clr = 1'b1;
    SD = 1'b0;
    MD = 1'b0;
    #1;
    check("async_clr_out", {22'd0, phase, MR, MY, MG, MA, SR, SY, SG}, {22'd0, expect_of(P_INIT)});
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1 clr = 1'b0;
    #1;
    check("clr_sd_req", {31'd0, dut.sd_req}, 32'd0);
    check("clr_md_req", {31'd0, dut.md_req}, 32'd0);
    check("clr_release_out", {22'd0, phase, MR, MY, MG, MA, SR, SY, SG}, {22'd0, expect_of(P_INIT)});

    // Restart from INIT, then more random traffic.
    repeat (5) drive(1'b0, 1'b0);
    for (int i = 0; i < 200; i++) begin
      drive($urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end
    repeat (10) drive(1'b0, 1'b0);

    repeat (2) @(negedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
